// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: byte-keep beats are folded into a CRC_W-bit LFSR
// register, and the final CRC plus a residue-match flag are held until accepted.
module crc_stream_engine #(
  parameter int          CRC_W   = 8,
  parameter logic [31:0] POLY    = 32'h07,
  parameter logic [31:0] INIT    = 32'h00,
  parameter logic [31:0] XOROUT  = 32'h00,
  parameter bit          REFIN   = 1'b0,
  parameter bit          REFOUT  = 1'b0,
  parameter logic [31:0] RESIDUE = 32'h00,
  parameter int          DATA_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic [DATA_W/8-1:0] s_keep_i,
  input  logic                s_last_i,
  output logic                crc_valid_o,
  input  logic                crc_ready_i,
  output logic [CRC_W-1:0]    crc_o,
  output logic                crc_ok_o,
  output logic                busy_o
);
  localparam int NL = DATA_W / 8;
  localparam logic [CRC_W-1:0] POLY_C    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_C  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];
  localparam logic [NL-1:0]    KEEP_ONE  = NL'(1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] reg_q, reg_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             ok_q, ok_d;
  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] beat_crc;
  logic [CRC_W-1:0] final_crc;
  logic             accept;

  // Eight serial LFSR steps; REFIN selects which end of the byte enters first.
  function automatic logic [CRC_W-1:0] byte_step(input logic [CRC_W-1:0] r, input logic [7:0] b);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = r;
    for (int i = 0; i < 8; i++) begin
      fb = c[CRC_W-1] ^ (REFIN ? b[i] : b[7-i]);
      c  = c << 1;
      if (fb) c = c ^ POLY_C;
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] r);
    logic [CRC_W-1:0] o;
    for (int i = 0; i < CRC_W; i++) o[i] = r[CRC_W-1-i];
    return o;
  endfunction

  function automatic logic keep_contiguous(input logic [NL-1:0] k);
    return ((k & (k + KEEP_ONE)) == '0);
  endfunction

  assign crc_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == ACC);
  assign crc_o       = crc_q;
  assign crc_ok_o    = ok_q;
  assign s_ready_o   = !rst_i && (!crc_valid_o || crc_ready_i);
  assign accept      = s_valid_i && s_ready_o;

  // A beat that opens a frame starts from INIT, never from a stale register.
  assign base = (state_q == ACC) ? reg_q : INIT_C;

  always_comb begin
    beat_crc = base;
    for (int i = 0; i < NL; i++) begin
      if (s_keep_i[i]) beat_crc = byte_step(beat_crc, s_data_i[8*i +: 8]);
    end
  end

  assign final_crc = (REFOUT ? bit_rev(beat_crc) : beat_crc) ^ XOROUT_C;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    if (clr_i) begin
      state_d = IDLE;
      reg_d   = INIT_C;
    end else begin
      if (state_q == DONE && crc_ready_i) state_d = IDLE;
      if (accept) begin
        reg_d = beat_crc;
        if (s_last_i) begin
          state_d = DONE;
          crc_d   = final_crc;
          ok_d    = (beat_crc == RESIDUE_C);
        end else begin
          state_d = ACC;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      reg_q   <= INIT_C;
      crc_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
    end
  end

  a_keep_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && !clr_i) |-> keep_contiguous(s_keep_i));

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: CRC-8 and Ethernet CRC-32 instances, directed cases plus
// random frames checked against a polynomial long-division reference.
module tb_crc_stream_engine;
  typedef struct { logic [31:0] crc; logic ok; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit rr_en = 1'b0;

  logic       v8 = 1'b0, l8 = 1'b0, clr8 = 1'b0, r8 = 1'b1;
  logic [0:0] k8 = 1'b0;
  logic [7:0] d8 = '0;
  logic       s_ready8, cv8, ok8, busy8;
  logic [7:0] crc8;

  logic        v32 = 1'b0, l32 = 1'b0, clr32 = 1'b0, r32 = 1'b1;
  logic [3:0]  k32 = '0;
  logic [31:0] d32 = '0;
  logic        s_ready32, cv32, ok32, busy32;
  logic [31:0] crc32;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  crc_stream_engine u8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8),
    .s_valid_i(v8), .s_ready_o(s_ready8), .s_data_i(d8), .s_keep_i(k8), .s_last_i(l8),
    .crc_valid_o(cv8), .crc_ready_i(r8), .crc_o(crc8), .crc_ok_o(ok8), .busy_o(busy8)
  );

  crc_stream_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(32'hC704DD7B), .DATA_W(32)
  ) u32 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr32),
    .s_valid_i(v32), .s_ready_o(s_ready32), .s_data_i(d32), .s_keep_i(k32), .s_last_i(l32),
    .crc_valid_o(cv32), .crc_ready_i(r32), .crc_o(crc32), .crc_ok_o(ok32), .busy_o(busy32)
  );

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Reference: register = (M(x)*x^W + INIT*x^n) mod P, by explicit long division.
  function automatic exp_t model(input byte unsigned msg[$], input int w,
                                 input logic [31:0] poly, input logic [31:0] init,
                                 input logic [31:0] xorout, input logic [31:0] residue,
                                 input bit refin, input bit refout);
    bit          dv[$];
    int          n;
    logic [31:0] r, o, mask;
    exp_t        e;
    foreach (msg[j]) for (int b = 0; b < 8; b++) dv.push_back(refin ? msg[j][b] : msg[j][7-b]);
    n = dv.size();
    for (int t = 0; t < w; t++) dv.push_back(1'b0);
    for (int t = 0; t < w; t++) dv[t] = dv[t] ^ init[w-1-t];
    for (int k = 0; k < n; k++) begin
      if (dv[k]) begin
        dv[k] = 1'b0;
        for (int t = 0; t < w; t++) dv[k+1+t] = dv[k+1+t] ^ poly[w-1-t];
      end
    end
    r = '0;
    for (int t = 0; t < w; t++) r[w-1-t] = dv[n+t];
    o = '0;
    for (int t = 0; t < w; t++) o[t] = r[w-1-t];
    mask  = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    e.crc = ((refout ? o : r) ^ xorout) & mask;
    e.ok  = (r == (residue & mask));
    return e;
  endfunction

  function automatic exp_t model8(input byte unsigned msg[$]);
    return model(msg, 8, 32'h07, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t model32(input byte unsigned msg[$]);
    return model(msg, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hC704DD7B, 1'b1, 1'b1);
  endfunction

  task automatic beat8(input logic [7:0] d, input logic k, input logic last, output bit acc);
    int n = 0;
    v8 = 1'b1; d8 = d; k8 = k; l8 = last; acc = 1'b0;
    if (rr_en) r8 = 1'($urandom_range(0, 1));
    while (n < 200) begin
      @(negedge clk);
      if (s_ready8) begin acc = 1'b1; break; end
      @(posedge clk); #1;
      if (rr_en) r8 = 1'($urandom_range(0, 1));
      n++;
    end
    if (acc) begin @(posedge clk); #1; end
    v8 = 1'b0; l8 = 1'b0;
    if (!acc) begin tests++; fails++; $display("FAIL beat8_timeout: got no s_ready, required s_ready within 200 cycles"); end
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic last, output bit acc);
    int n = 0;
    v32 = 1'b1; d32 = d; k32 = k; l32 = last; acc = 1'b0;
    if (rr_en) r32 = 1'($urandom_range(0, 1));
    while (n < 200) begin
      @(negedge clk);
      if (s_ready32) begin acc = 1'b1; break; end
      @(posedge clk); #1;
      if (rr_en) r32 = 1'($urandom_range(0, 1));
      n++;
    end
    if (acc) begin @(posedge clk); #1; end
    v32 = 1'b0; l32 = 1'b0;
    if (!acc) begin tests++; fails++; $display("FAIL beat32_timeout: got no s_ready, required s_ready within 200 cycles"); end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      if (rr_en) begin r8 = 1'($urandom_range(0, 1)); r32 = 1'($urandom_range(0, 1)); end
      @(posedge clk); #1;
    end
  endtask

  // Sends msg[skip..] as one-byte beats; the expectation covers the whole msg.
  task automatic frame8(input byte unsigned msg[$], input int skip, input bit rnd);
    bit acc;
    for (int i = skip; i < msg.size(); i++) begin
      if (rnd) begin
        idle_cycles($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin
          beat8(8'($urandom), 1'b0, 1'b0, acc);
          if (!acc) return;
        end
      end
      beat8(msg[i], 1'b1, (i == msg.size() - 1), acc);
      if (!acc) return;
    end
    q8.push_back(model8(msg));
  endtask

  task automatic frame32(input byte unsigned msg[$], input bit rnd);
    int          i = 0;
    int          nb;
    logic [31:0] d;
    logic [3:0]  k;
    bit          acc, last;
    do begin
      nb = rnd ? $urandom_range(0, 4) : 4;
      if (nb > msg.size() - i) nb = msg.size() - i;
      d = $urandom;
      k = '0;
      for (int b = 0; b < nb; b++) begin d[8*b +: 8] = msg[i+b]; k[b] = 1'b1; end
      i += nb;
      last = (i == msg.size());
      if (rnd) idle_cycles($urandom_range(0, 2));
      beat32(d, k, last, acc);
      if (!acc) return;
    end while (!last);
    q32.push_back(model32(msg));
  endtask

  always @(negedge clk) begin
    if (!rst && cv8 && r8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb8_unexpected: got result %h, required no result", crc8);
      end else begin
        e8 = q8.pop_front();
        checkv("sb8_crc", 32'(crc8), 32'(e8.crc[7:0]));
        check1("sb8_ok", ok8, e8.ok);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cv32 && r32) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb32_unexpected: got result %h, required no result", crc32);
      end else begin
        e32 = q32.pop_front();
        checkv("sb32_crc", crc32, e32.crc);
        check1("sb32_ok", ok32, e32.ok);
      end
    end
  end

  initial begin
    byte unsigned m[$];
    byte unsigned c[$];
    bit           acc;
    int           n;
    m = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (2) @(negedge clk);
    check1("rst_ready8", s_ready8, 1'b0);
    check1("rst_valid8", cv8, 1'b0);
    checkv("rst_crc8", 32'(crc8), 32'h0);
    check1("rst_ok8", ok8, 1'b0);
    check1("rst_busy8", busy8, 1'b0);
    check1("rst_ready32", s_ready32, 1'b0);
    checkv("rst_crc32", crc32, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", s_ready8, 1'b1);
    @(posedge clk); #1;

    frame8(m, 0, 1'b0);
    @(negedge clk);
    check1("t1_valid", cv8, 1'b1);
    checkv("t1_crc", 32'(crc8), 32'hF4);
    @(posedge clk); #1;

    c = m; c.push_back(8'hF4);
    frame8(c, 0, 1'b0);
    @(negedge clk);
    checkv("t2_crc", 32'(crc8), 32'h00);
    check1("t2_ok", ok8, 1'b1);
    @(posedge clk); #1;
    c[4] = c[4] ^ 8'h10;
    frame8(c, 0, 1'b0);
    @(negedge clk);
    check1("t2_bad_ok", ok8, 1'b0);
    @(posedge clk); #1;

    r32 = 1'b0;
    frame32(m, 1'b0);
    @(negedge clk);
    check1("t3_valid", cv32, 1'b1);
    checkv("t3_crc", crc32, 32'hCBF43926);
    @(posedge clk); #1 r32 = 1'b1;
    c = m;
    c.push_back(8'h26); c.push_back(8'h39); c.push_back(8'hF4); c.push_back(8'hCB);
    frame32(c, 1'b0);
    idle_cycles(2);

    r8 = 1'b0;
    frame8(m, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("t4_hold_ready", s_ready8, 1'b0);
      check1("t4_hold_valid", cv8, 1'b1);
      checkv("t4_hold_crc", 32'(crc8), 32'hF4);
      @(posedge clk); #1;
    end
    r8 = 1'b1; v8 = 1'b1; d8 = m[0]; k8 = 1'b1; l8 = 1'b0;
    @(negedge clk);
    check1("t4_both_ready", s_ready8, 1'b1);
    check1("t4_both_valid", cv8, 1'b1);
    @(posedge clk); #1 v8 = 1'b0;
    frame8(m, 1, 1'b0);
    @(negedge clk);
    checkv("t4_next_crc", 32'(crc8), 32'hF4);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) beat8(m[i], 1'b1, 1'b0, acc);
    idle_cycles(3);
    @(negedge clk);
    check1("t5_busy_gap", busy8, 1'b1);
    @(posedge clk); #1;
    clr8 = 1'b1; v8 = 1'b1; d8 = 8'hA5; k8 = 1'b1; l8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0; v8 = 1'b0; l8 = 1'b0;
    @(negedge clk);
    check1("t5_busy_clr", busy8, 1'b0);
    check1("t5_valid_clr", cv8, 1'b0);
    @(posedge clk); #1;
    frame8(m, 0, 1'b0);
    @(negedge clk);
    checkv("t5_crc", 32'(crc8), 32'hF4);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) beat8(m[i], 1'b1, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    check1("t6_frame_busy", busy8, 1'b0);
    check1("t6_frame_ready", s_ready8, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    r8 = 1'b0;
    frame8(m, 0, 1'b0);
    @(negedge clk);
    check1("t6_hold_valid", cv8, 1'b1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check1("t6_hold_valid_rst", cv8, 1'b0);
    checkv("t6_hold_crc_rst", 32'(crc8), 32'h0);
    check1("t6_hold_ok_rst", ok8, 1'b0);
    q8.delete();
    @(posedge clk); #1 rst = 1'b0; r8 = 1'b1;
    frame8(m, 0, 1'b0);
    @(negedge clk);
    checkv("t6_fresh_crc", 32'(crc8), 32'hF4);
    @(posedge clk); #1;

    rr_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      c.delete();
      n = $urandom_range(1, 12);
      repeat (n) c.push_back(8'($urandom));
      frame8(c, 0, 1'b1);
    end
    rr_en = 1'b0; r8 = 1'b1;
    idle_cycles(3);
    rr_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      c.delete();
      n = $urandom_range(0, 14);
      repeat (n) c.push_back(8'($urandom));
      frame32(c, 1'b1);
    end
    rr_en = 1'b0; r8 = 1'b1; r32 = 1'b1;
    idle_cycles(5);
    checkv("q8_drained", 32'(q8.size()), 32'h0);
    checkv("q32_drained", 32'(q32.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
